// File: rtl/riscv32_pkg.sv
// Shared RV32I constants for the single-cycle core: opcodes, funct3 codes, ALU operations,
// writeback selects, the decoded control bundle and a memory word-index helper.
package riscv32_pkg;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcImm    = 7'b0010011;
    localparam logic [6:0] OpcReg    = 7'b0110011;

    // Integer-op funct3
    localparam logic [2:0] F3Add  = 3'b000;
    localparam logic [2:0] F3Sll  = 3'b001;
    localparam logic [2:0] F3Slt  = 3'b010;
    localparam logic [2:0] F3Sltu = 3'b011;
    localparam logic [2:0] F3Xor  = 3'b100;
    localparam logic [2:0] F3Sr   = 3'b101;
    localparam logic [2:0] F3Or   = 3'b110;
    localparam logic [2:0] F3And  = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

    // Load/store funct3
    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor,
        AluSrl, AluSra, AluOr, AluAnd, AluPassB
    } alu_op_e;

    typedef enum logic [1:0] {WbAlu, WbMem, WbPc4} wb_sel_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_write;
        logic    alu_src_pc;   // operand A = PC instead of rs1
        logic    alu_src_imm;  // operand B = immediate instead of rs2
        alu_op_e alu_op;
        wb_sel_e wb_sel;
        logic    branch;
        logic    jal;
        logic    jalr;
    } ctrl_t;

    function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        op = AluAdd;
        case (funct3)
            F3Add:   op = alt ? AluSub : AluAdd;
            F3Sll:   op = AluSll;
            F3Slt:   op = AluSlt;
            F3Sltu:  op = AluSltu;
            F3Xor:   op = AluXor;
            F3Sr:    op = alt ? AluSra : AluSrl;
            F3Or:    op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    // Byte address -> word index, wrapped to the memory depth.
    function automatic logic [29:0] word_index(input logic [31:0] addr,
                                               input int unsigned depth);
        return 30'(addr[31:2] % depth);
    endfunction

endpackage

// File: rtl/riscv32_control.sv
// Instruction decoder and immediate generator. Unrecognised or malformed encodings
// (including FENCE/ECALL/EBREAK) decode to an all-zero control word, i.e. a NOP.
// Ports: instr (in), ctrl (decoded control bundle), imm (selected sign-extended immediate).
module riscv32_control
    import riscv32_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic [31:0] imm
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        shift_ok;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Only SRL/SRA (and SUB for register ops) may use the alternate funct7.
    assign shift_ok = (funct7 == 7'b0000000) || ((funct7 == 7'b0100000) && (funct3 == F3Sr));

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = AluAdd;
        ctrl.wb_sel = WbAlu;
        imm         = imm_i;
        case (opcode)
            OpcLui: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.alu_op      = AluPassB;
                imm              = imm_u;
            end
            OpcAuipc: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_pc  = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                imm              = imm_u;
            end
            OpcJal: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WbPc4;
                ctrl.jal       = 1'b1;
                imm            = imm_j;
            end
            OpcJalr: begin
                if (funct3 == 3'b000) begin
                    ctrl.reg_write   = 1'b1;
                    ctrl.wb_sel      = WbPc4;
                    ctrl.jalr        = 1'b1;
                    ctrl.alu_src_imm = 1'b1;
                end
            end
            OpcBranch: begin
                ctrl.branch = (funct3[2:1] != 2'b01);
                imm         = imm_b;
            end
            OpcLoad: begin
                if (funct3 == F3Byte || funct3 == F3Half || funct3 == F3Word ||
                    funct3 == F3ByteU || funct3 == F3HalfU) begin
                    ctrl.reg_write   = 1'b1;
                    ctrl.alu_src_imm = 1'b1;
                    ctrl.wb_sel      = WbMem;
                end
            end
            OpcStore: begin
                imm = imm_s;
                if (funct3 == F3Byte || funct3 == F3Half || funct3 == F3Word) begin
                    ctrl.mem_write   = 1'b1;
                    ctrl.alu_src_imm = 1'b1;
                end
            end
            OpcImm: begin
                if ((funct3 != F3Sll && funct3 != F3Sr) || shift_ok) begin
                    ctrl.reg_write   = 1'b1;
                    ctrl.alu_src_imm = 1'b1;
                    // Bit 30 is immediate data for ADDI, so it selects only SRAI.
                    ctrl.alu_op      = alu_decode(funct3, (funct3 == F3Sr) && funct7[5]);
                end
            end
            OpcReg: begin
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == F3Add || funct3 == F3Sr))) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = alu_decode(funct3, funct7[5]);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv32_dmem.sv
// Data memory: combinational word read, synchronous byte-enabled write. Not reset.
// Ports: clk, addr (byte address), we, be[3:0], wdata, rdata (word at addr).
module riscv32_dmem
    import riscv32_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]   mem [0:DEPTH_WORDS-1];
    logic [29:0]   word_idx;
    logic [AW-1:0] idx;
    logic          unused_bits;

    assign word_idx    = word_index(addr, DEPTH_WORDS);
    assign idx         = word_idx[AW-1:0];
    assign rdata       = mem[idx];
    assign unused_bits = ^{addr[1:0], word_idx[29:AW]};

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/riscv32_imem.sv
// Instruction memory, combinational read; contents are loaded from outside the core.
// Ports: addr (byte address, low two bits ignored), instr (word at addr).
module riscv32_imem
    import riscv32_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic [31:0] addr,
    output logic [31:0] instr
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]   mem [0:DEPTH_WORDS-1];
    logic [29:0]   word_idx;
    logic [AW-1:0] idx;
    logic          unused_bits;

    assign word_idx    = word_index(addr, DEPTH_WORDS);
    assign idx         = word_idx[AW-1:0];
    assign instr       = mem[idx];
    assign unused_bits = ^{addr[1:0], word_idx[29:AW]};

endmodule

// File: rtl/riscv32_pc_reg.sv
// Program counter register.
// Ports: clk, rst (async, active-high, clears PC to 0), pc_next (in), pc_current (out).
module riscv32_pc_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_next,
    output logic [31:0] pc_current
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_current <= '0;
        end else begin
            pc_current <= pc_next;
        end
    end

endmodule

// File: rtl/riscv32_regfile.sv
// 32 x 32-bit register file, two combinational read ports, one write port.
// Ports: clk, rst (async clear of all registers), rs1_addr/rs2_addr -> rs1_data/rs2_data,
//        rd_addr, rd_we, rd_data. x0 reads as zero and ignores writes.
module riscv32_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [4:0]  rd_addr,
    input  logic        rd_we,
    input  logic [31:0] rd_data,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data
);

    logic [31:0] regs [0:31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (rd_we && (rd_addr != 5'd0)) begin
            regs[rd_addr] <= rd_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/riscv32_singlecycle_top.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and writeback all settle within one
// clk cycle; PC, register file and data memory commit on the rising edge.
// Ports: clk (single clock), rst (asynchronous, active-high). Observed via internal hierarchy.
module riscv32_singlecycle_top
    import riscv32_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH_WORDS = 4096,
    parameter int unsigned DMEM_DEPTH_WORDS = 256
) (
    input logic clk,
    input logic rst
);

    logic [31:0] pc_current, pc_next, pc_plus4, pc_target;
    logic [31:0] instr, imm, rs1_val, rs2_val, rd_val;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [31:0] dmem_rdata, ld_shifted, ld_val, st_data;
    logic [3:0]  st_be;
    logic [1:0]  st_off;
    logic [2:0]  funct3;
    logic        cond, branch_taken;
    ctrl_t       ctrl;

    assign funct3 = instr[14:12];

    riscv32_pc_reg u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .pc_next    (pc_next),
        .pc_current (pc_current)
    );

    riscv32_imem #(.DEPTH_WORDS(IMEM_DEPTH_WORDS)) u_imem (
        .addr  (pc_current),
        .instr (instr)
    );

    riscv32_control u_control (
        .instr (instr),
        .ctrl  (ctrl),
        .imm   (imm)
    );

    riscv32_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (instr[19:15]),
        .rs2_addr (instr[24:20]),
        .rd_addr  (instr[11:7]),
        .rd_we    (ctrl.reg_write),
        .rd_data  (rd_val),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val)
    );

    // Gated by rst so an edge seen while reset is held never commits a store.
    riscv32_dmem #(.DEPTH_WORDS(DMEM_DEPTH_WORDS)) u_dmem (
        .clk   (clk),
        .addr  (alu_y),
        .we    (ctrl.mem_write & ~rst),
        .be    (st_be),
        .wdata (st_data),
        .rdata (dmem_rdata)
    );

    assign alu_a = ctrl.alu_src_pc ? pc_current : rs1_val;
    assign alu_b = ctrl.alu_src_imm ? imm : rs2_val;

    always_comb begin
        alu_y = '0;
        case (ctrl.alu_op)
            AluAdd:   alu_y = alu_a + alu_b;
            AluSub:   alu_y = alu_a - alu_b;
            AluSll:   alu_y = alu_a << alu_b[4:0];
            AluSlt:   alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
            AluSltu:  alu_y = {31'b0, alu_a < alu_b};
            AluXor:   alu_y = alu_a ^ alu_b;
            AluSrl:   alu_y = alu_a >> alu_b[4:0];
            AluSra:   alu_y = 32'($signed(alu_a) >>> alu_b[4:0]);
            AluOr:    alu_y = alu_a | alu_b;
            AluAnd:   alu_y = alu_a & alu_b;
            AluPassB: alu_y = alu_b;
            default:  alu_y = '0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3Beq:   cond = (rs1_val == rs2_val);
            F3Bne:   cond = (rs1_val != rs2_val);
            F3Blt:   cond = ($signed(rs1_val) < $signed(rs2_val));
            F3Bge:   cond = ($signed(rs1_val) >= $signed(rs2_val));
            F3Bltu:  cond = (rs1_val < rs2_val);
            F3Bgeu:  cond = (rs1_val >= rs2_val);
            default: cond = 1'b0;
        endcase
        branch_taken = ctrl.branch && cond;
    end

    assign pc_plus4  = pc_current + 32'd4;
    assign pc_target = pc_current + imm;
    assign pc_next   = ctrl.jalr ? {alu_y[31:1], 1'b0} :
                       (ctrl.jal || branch_taken) ? pc_target : pc_plus4;

    // Loads: move the addressed lane down to bit 0, then extend.
    assign ld_shifted = dmem_rdata >> {alu_y[1:0], 3'b000};

    always_comb begin
        case (funct3)
            F3Byte:  ld_val = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            F3Half:  ld_val = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            F3ByteU: ld_val = {24'b0, ld_shifted[7:0]};
            F3HalfU: ld_val = {16'b0, ld_shifted[15:0]};
            default: ld_val = dmem_rdata;
        endcase
    end

    // Stores: byte lane offset within the word, aligned down to the access size.
    always_comb begin
        case (funct3)
            F3Byte: begin
                st_off = alu_y[1:0];
                st_be  = 4'b0001 << st_off;
            end
            F3Half: begin
                st_off = {alu_y[1], 1'b0};
                st_be  = 4'b0011 << st_off;
            end
            default: begin
                st_off = 2'b00;
                st_be  = 4'b1111;
            end
        endcase
        st_data = rs2_val << {st_off, 3'b000};
    end

    always_comb begin
        case (ctrl.wb_sel)
            WbMem:   rd_val = ld_val;
            WbPc4:   rd_val = pc_plus4;
            default: rd_val = alu_y;
        endcase
    end

endmodule

// File: tb/tb_riscv32_singlecycle_top.sv
module tb_riscv32_singlecycle_top;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    riscv32_singlecycle_top #(
        .IMEM_DEPTH_WORDS (4096),
        .DMEM_DEPTH_WORDS (256)
    ) dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // One executed instruction: PC before the edge, PC after it, and the register it writes.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] next_pc;
        int          rd;      // -1: no register to check
        logic [31:0] val;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1,
                                          input int f3);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                          input int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm20;
        return {v[19:0], 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        dut.u_imem.mem[addr[31:2]] = word;
    endtask

    task automatic add_vec(input logic [31:0] pc, input logic [31:0] npc, input int rd,
                           input logic [31:0] val);
        vec_t v;
        v.pc = pc;
        v.next_pc = npc;
        v.rd = rd;
        v.val = val;
        vecs.push_back(v);
    endtask

    // Issue one instruction per vector; its expectation is scored one edge later.
    task automatic run_vecs(input string tag);
        foreach (vecs[i]) begin
            vec_t e;
            check($sformatf("%s_pc_%0d", tag, i), dut.u_pc_reg.pc_current, vecs[i].pc);
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("%s_npc_%0d", tag, i), dut.u_pc_reg.pc_current, e.next_pc);
            if (e.rd >= 0) begin
                check($sformatf("%s_x%0d_%0d", tag, e.rd, i), dut.u_regfile.regs[e.rd], e.val);
            end
        end
        vecs.delete();
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 4096; i++) dut.u_imem.mem[i] = 32'h0000_0013;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_imem();
        for (int i = 0; i < 256; i++) dut.u_dmem.mem[i] = 32'h0;

        // Program 1: ALU, reset-zero sources, store/load, forward and backward control flow
        put(32'h00, 32'h0000_0013);
        put(32'h04, enc_i(10, 0, 0, 1, OP_IMM));
        put(32'h08, enc_i(20, 0, 0, 2, OP_IMM));
        put(32'h0C, enc_r(0, 2, 1, 0, 3));
        put(32'h10, enc_r(32, 2, 1, 0, 4));
        put(32'h14, enc_i(2, 1, 1, 8, OP_IMM));
        put(32'h18, enc_i(1, 3, 5, 9, OP_IMM));
        put(32'h1C, enc_i(255, 7, 7, 5, OP_IMM));
        put(32'h20, enc_r(0, 25, 2, 3, 11));
        put(32'h24, enc_i(240, 2, 6, 6, OP_IMM));
        put(32'h28, enc_i(85, 5, 4, 7, OP_IMM));
        put(32'h2C, enc_i(15, 1, 2, 10, OP_IMM));
        put(32'h30, enc_s(0, 3, 0, 2));
        put(32'h34, enc_i(0, 0, 2, 12, OP_LOAD));
        put(32'h38, enc_b(8, 12, 3, 0));
        put(32'h3C, enc_i(99, 0, 0, 13, OP_IMM));
        put(32'h40, enc_j(8, 15));
        put(32'h44, enc_i(1, 0, 0, 14, OP_IMM));
        put(32'h48, enc_u(0, 16, OP_AUIPC));
        put(32'h4C, enc_i(5, 0, 0, 0, OP_IMM));
        put(32'h50, enc_b(-20, 0, 0, 0));

        add_vec(32'h00, 32'h04,  0, 32'h0);
        add_vec(32'h04, 32'h08,  1, 32'd10);
        add_vec(32'h08, 32'h0C,  2, 32'd20);
        add_vec(32'h0C, 32'h10,  3, 32'd30);
        add_vec(32'h10, 32'h14,  4, 32'hFFFF_FFF6);
        add_vec(32'h14, 32'h18,  8, 32'd40);
        add_vec(32'h18, 32'h1C,  9, 32'd15);
        add_vec(32'h1C, 32'h20,  5, 32'd0);
        add_vec(32'h20, 32'h24, 11, 32'd0);
        add_vec(32'h24, 32'h28,  6, 32'd244);
        add_vec(32'h28, 32'h2C,  7, 32'd85);
        add_vec(32'h2C, 32'h30, 10, 32'd1);
        add_vec(32'h30, 32'h34, -1, 32'h0);
        add_vec(32'h34, 32'h38, 12, 32'd30);
        add_vec(32'h38, 32'h40, -1, 32'h0);
        add_vec(32'h40, 32'h48, 15, 32'h44);
        add_vec(32'h48, 32'h4C, 16, 32'h48);
        add_vec(32'h4C, 32'h50,  0, 32'h0);
        add_vec(32'h50, 32'h3C, -1, 32'h0);
        add_vec(32'h3C, 32'h40, 13, 32'd99);
        add_vec(32'h40, 32'h48, 15, 32'h44);
        add_vec(32'h48, 32'h4C, 16, 32'h48);
        add_vec(32'h4C, 32'h50,  0, 32'h0);
        add_vec(32'h50, 32'h3C, -1, 32'h0);

        // Release reset between edges: first fetch must already be visible.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_pc", dut.u_pc_reg.pc_current, 32'h0);
        check("reset_instr", dut.u_imem.instr, 32'h0000_0013);
        check("reset_x7", dut.u_regfile.regs[7], 32'h0);

        run_vecs("p1");
        check("sw_dmem0", dut.u_dmem.mem[0], 32'd30);
        check("jal_skipped_x14", dut.u_regfile.regs[14], 32'h0);

        // Reset asserted mid-cycle acts immediately on PC and registers.
        rst = 1'b1;
        #1;
        check("async_rst_pc", dut.u_pc_reg.pc_current, 32'h0);
        check("async_rst_x13", dut.u_regfile.regs[13], 32'h0);

        // Program 2: sub-word memory, signed/unsigned compares, JALR, system NOP, SRA, wrap
        clear_imem();
        put(32'h00, enc_u(32'h80000, 1, OP_LUI));
        put(32'h04, enc_i(-1, 0, 0, 2, OP_IMM));
        put(32'h08, enc_s(5, 2, 0, 0));
        put(32'h0C, enc_i(5, 0, 0, 3, OP_LOAD));
        put(32'h10, enc_i(5, 0, 4, 4, OP_LOAD));
        put(32'h14, enc_s(2, 2, 0, 1));
        put(32'h18, enc_i(2, 0, 1, 5, OP_LOAD));
        put(32'h1C, enc_i(2, 0, 5, 6, OP_LOAD));
        put(32'h20, enc_b(8, 0, 1, 4));
        put(32'h24, enc_i(1, 0, 0, 7, OP_IMM));
        put(32'h28, enc_b(8, 0, 1, 6));
        put(32'h2C, enc_r(0, 2, 1, 2, 8));
        put(32'h30, enc_i(32'h41, 0, 0, 9, OP_JALR));
        put(32'h34, enc_i(2, 0, 0, 7, OP_IMM));
        put(32'h40, 32'h0000_0073);
        put(32'h44, enc_i(32'h404, 1, 5, 10, OP_IMM));
        put(32'h48, enc_r(0, 1, 1, 0, 11));
        put(32'h4C, enc_j(0, 0));

        add_vec(32'h00, 32'h04,  1, 32'h8000_0000);
        add_vec(32'h04, 32'h08,  2, 32'hFFFF_FFFF);
        add_vec(32'h08, 32'h0C, -1, 32'h0);
        add_vec(32'h0C, 32'h10,  3, 32'hFFFF_FFFF);
        add_vec(32'h10, 32'h14,  4, 32'h0000_00FF);
        add_vec(32'h14, 32'h18, -1, 32'h0);
        add_vec(32'h18, 32'h1C,  5, 32'hFFFF_FFFF);
        add_vec(32'h1C, 32'h20,  6, 32'h0000_FFFF);
        add_vec(32'h20, 32'h28, -1, 32'h0);
        add_vec(32'h28, 32'h2C, -1, 32'h0);
        add_vec(32'h2C, 32'h30,  8, 32'd1);
        add_vec(32'h30, 32'h40,  9, 32'h34);
        add_vec(32'h40, 32'h44, -1, 32'h0);
        add_vec(32'h44, 32'h48, 10, 32'hF800_0000);
        add_vec(32'h48, 32'h4C, 11, 32'h0);
        add_vec(32'h4C, 32'h4C,  0, 32'h0);
        add_vec(32'h4C, 32'h4C, -1, 32'h0);

        @(posedge clk);
        #1;
        check("rst_hold_x12", dut.u_regfile.regs[12], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("p2_reset_instr", dut.u_imem.instr, enc_u(32'h80000, 1, OP_LUI));
        check("dmem_kept", dut.u_dmem.mem[0], 32'd30);

        run_vecs("p2");
        check("sb_dmem1", dut.u_dmem.mem[1], 32'h0000_FF00);
        check("sh_dmem0", dut.u_dmem.mem[0], 32'hFFFF_001E);
        check("skipped_x7", dut.u_regfile.regs[7], 32'h0);

        // Store issued while reset is held must not reach memory.
        rst = 1'b1;
        #1;
        check("abort_pc", dut.u_pc_reg.pc_current, 32'h0);
        put(32'h00, enc_s(0, 0, 0, 2));
        @(posedge clk);
        #1;
        check("abort_no_store", dut.u_dmem.mem[0], 32'hFFFF_001E);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
